// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory-stage controller: default widths, the
// stack-pointer reset value, the decoded memory-operation enum, the controller
// FSM state enum, and small helpers for decoding and classifying operations.
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam int DEF_DATA_W      = 16;
  localparam int DEF_ADDR_W      = 11;
  localparam int DEF_SP_RESET    = (1 << DEF_ADDR_W) - 1;
  localparam int DEF_TIMEOUT_CYC = 64;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_LOAD,
    OP_STORE,
    OP_PUSH,
    OP_POP
  } op_e;

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_e;

  // Priority push > pop > store > load; a bubble never selects an operation.
  function automatic op_e decode_op(input logic valid, input logic push,
                                    input logic pop, input logic wr,
                                    input logic rd);
    if (!valid)    return OP_NONE;
    else if (push) return OP_PUSH;
    else if (pop)  return OP_POP;
    else if (wr)   return OP_STORE;
    else if (rd)   return OP_LOAD;
    else           return OP_NONE;
  endfunction

  function automatic logic op_is_read(input op_e op);
    return (op == OP_LOAD) || (op == OP_POP);
  endfunction

  function automatic logic op_is_write(input op_e op);
    return (op == OP_STORE) || (op == OP_PUSH);
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_sp_unit.sv
// -----------------------------------------------------------------------------
// sp_unit
// Stack-pointer register with modulo-2**ADDR_W arithmetic and the push/pop
// address mux. Push uses SP then post-decrements; pop pre-increments and uses
// SP+1.
//   clk, rst_n  : clock, asynchronous active-low reset (SP <= SP_RESET)
//   push_i      : commit a push this cycle (SP <= SP-1)
//   pop_i       : commit a pop this cycle  (SP <= SP+1)
//   sp_o        : current SP
//   addr_o      : stack access address for the operation being committed
// -----------------------------------------------------------------------------
module sp_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int SP_RESET = DEF_SP_RESET
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  output logic [ADDR_W-1:0] sp_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] sp_q;
  logic [ADDR_W-1:0] sp_d;
  logic [ADDR_W-1:0] sp_inc;
  logic [ADDR_W-1:0] sp_dec;

  // Truncation to ADDR_W bits gives the wrap-around for free.
  assign sp_inc = sp_q + ADDR_W'(1);
  assign sp_dec = sp_q - ADDR_W'(1);

  assign addr_o = pop_i ? sp_inc : sp_q;
  assign sp_o   = sp_q;

  always_comb begin
    // NOTE: default assignment first so every path drives sp_d; no latch.
    sp_d = sp_q;
    if (push_i)     sp_d = sp_dec;
    else if (pop_i) sp_d = sp_inc;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp_q <= ADDR_W'(SP_RESET);
    else        sp_q <= sp_d;
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
// Memory-stage controller between EX/MEM and MEM/WB. Decodes load/store/
// push/pop, owns the stack pointer, runs a req/ready handshake with data
// memory, stalls the pipeline for the access and registers the MEM/WB outputs.
//
// Optional feature (macro MEM_STAGE_TIMEOUT_EN): adds parameter TIMEOUT_CYC
// and output mem_timeout; an access with no mem_ready for TIMEOUT_CYC cycles
// is abandoned with a bubble writeback and a one-cycle mem_timeout pulse.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   exmem_*               decoded instruction from EX/MEM
//   mem_req/we/addr/wdata request to data memory (held until mem_ready)
//   mem_ready, mem_rdata  memory completion and read data
//   dataFromMemory, MEMWB_* registered results to MEM/WB
//   mem_stall             freeze upstream pipeline stages
//   sp                    current stack pointer
//   mem_timeout           (optional) access-abandoned pulse
// -----------------------------------------------------------------------------
module mem_stage_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int SP_RESET = DEF_SP_RESET
`ifdef MEM_STAGE_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exmem_valid,
  input  logic              exmem_memRead,
  input  logic              exmem_memWrite,
  input  logic              exmem_push,
  input  logic              exmem_pop,
  input  logic [DATA_W-1:0] exmem_alu_result,
  input  logic [DATA_W-1:0] exmem_store_data,
  input  logic [2:0]        exmem_rdst,
  input  logic              exmem_wb,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] dataFromMemory,
  output logic [DATA_W-1:0] MEMWB_ALU_result,
  output logic [2:0]        MEMWB_Rdst_address,
  output logic              MEMWB_memRead,
  output logic              MEMWB,
  output logic              mem_stall,
  output logic [ADDR_W-1:0] sp
`ifdef MEM_STAGE_TIMEOUT_EN
  ,
  output logic              mem_timeout
`endif
);

  state_e            state_q;
  op_e               op_sel;
  op_e               op_q;
  logic              start;
  logic              tmo_hit;
  logic [ADDR_W-1:0] sp_addr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] alu_q;
  logic [2:0]        rdst_q;
  logic              wb_q;
  logic [DATA_W-1:0] dfm_q;
  logic [DATA_W-1:0] wb_alu_q;
  logic [2:0]        wb_rdst_q;
  logic              wb_rd_q;
  logic              wb_en_q;

  assign op_sel = decode_op(exmem_valid, exmem_push, exmem_pop,
                            exmem_memWrite, exmem_memRead);
  // A memory op seen in IDLE stalls in the same cycle, before ACCESS is entered.
  assign start  = (state_q == S_IDLE) && (op_sel != OP_NONE);

  sp_unit #(
    .ADDR_W   (ADDR_W),
    .SP_RESET (SP_RESET)
  ) u_sp (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (start && (op_sel == OP_PUSH)),
    .pop_i  (start && (op_sel == OP_POP)),
    .sp_o   (sp),
    .addr_o (sp_addr)
  );

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] tmo_cnt_q;
  logic             tmo_q;

  assign tmo_hit     = (tmo_cnt_q == TMO_LAST);
  assign mem_timeout = tmo_q;
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset too, because their zero values are visible on output ports.
      state_q   <= S_IDLE;
      op_q      <= OP_NONE;
      addr_q    <= '0;
      wdata_q   <= '0;
      alu_q     <= '0;
      rdst_q    <= '0;
      wb_q      <= 1'b0;
      dfm_q     <= '0;
      wb_alu_q  <= '0;
      wb_rdst_q <= '0;
      wb_rd_q   <= 1'b0;
      wb_en_q   <= 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
`endif
    end else begin
`ifdef MEM_STAGE_TIMEOUT_EN
      tmo_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (op_sel != OP_NONE) begin
            state_q <= S_ACCESS;
            op_q    <= op_sel;
            addr_q  <= ((op_sel == OP_PUSH) || (op_sel == OP_POP))
                       ? sp_addr : exmem_alu_result[ADDR_W-1:0];
            wdata_q <= exmem_store_data;
            alu_q   <= exmem_alu_result;
            rdst_q  <= exmem_rdst;
            wb_q    <= exmem_wb;
            wb_en_q <= 1'b0;
            wb_rd_q <= 1'b0;
            dfm_q   <= '0;
`ifdef MEM_STAGE_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
          end else begin
            // Pass-through: one-cycle latency; a bubble yields MEMWB = 0.
            wb_alu_q  <= exmem_alu_result;
            wb_rdst_q <= exmem_rdst;
            wb_en_q   <= exmem_valid & exmem_wb;
            wb_rd_q   <= 1'b0;
            dfm_q     <= '0;
          end
        end
        S_ACCESS: begin
          if (mem_ready) begin
            state_q   <= S_IDLE;
            wb_alu_q  <= alu_q;
            wb_rdst_q <= rdst_q;
            wb_en_q   <= wb_q;
            wb_rd_q   <= op_is_read(op_q);
            dfm_q     <= op_is_read(op_q) ? mem_rdata : '0;
          end else begin
            // Waiting cycles present bubbles so MEM/WB writes back only once.
            wb_en_q <= 1'b0;
            wb_rd_q <= 1'b0;
            dfm_q   <= '0;
            if (tmo_hit) state_q <= S_IDLE;
`ifdef MEM_STAGE_TIMEOUT_EN
            if (tmo_hit) tmo_q <= 1'b1;
            else         tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_req            = (state_q == S_ACCESS);
  assign mem_we             = mem_req && op_is_write(op_q);
  assign mem_addr           = addr_q;
  assign mem_wdata          = wdata_q;
  assign mem_stall          = mem_req || start;
  assign dataFromMemory     = dfm_q;
  assign MEMWB_ALU_result   = wb_alu_q;
  assign MEMWB_Rdst_address = wb_rdst_q;
  assign MEMWB_memRead      = wb_rd_q;
  assign MEMWB              = wb_en_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_ctrl
// Self-checking bench for mem_stage_ctrl. A word-array memory, an integer
// stack pointer and the operation priority rules form the reference model.
// Directed scenarios cover reset, pass-through, a multi-cycle load, push/pop,
// SP wrap, priority and reset during an access; a randomized instruction
// stream with random memory latency follows. Define MEM_STAGE_TIMEOUT_EN to
// also exercise the watchdog.
// -----------------------------------------------------------------------------
module tb_mem_stage_ctrl;

  localparam int DW    = 16;
  localparam int AW    = 11;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          exmem_valid, exmem_memRead, exmem_memWrite, exmem_push, exmem_pop;
  logic [DW-1:0] exmem_alu_result, exmem_store_data;
  logic [2:0]    exmem_rdst;
  logic          exmem_wb;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] dataFromMemory, MEMWB_ALU_result;
  logic [2:0]    MEMWB_Rdst_address;
  logic          MEMWB_memRead, MEMWB, mem_stall;
  logic [AW-1:0] sp;
`ifdef MEM_STAGE_TIMEOUT_EN
  logic          mem_timeout;
`endif

  mem_stage_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .exmem_valid        (exmem_valid),
    .exmem_memRead      (exmem_memRead),
    .exmem_memWrite     (exmem_memWrite),
    .exmem_push         (exmem_push),
    .exmem_pop          (exmem_pop),
    .exmem_alu_result   (exmem_alu_result),
    .exmem_store_data   (exmem_store_data),
    .exmem_rdst         (exmem_rdst),
    .exmem_wb           (exmem_wb),
    .mem_req            (mem_req),
    .mem_we             (mem_we),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_ready          (mem_ready),
    .mem_rdata          (mem_rdata),
    .dataFromMemory     (dataFromMemory),
    .MEMWB_ALU_result   (MEMWB_ALU_result),
    .MEMWB_Rdst_address (MEMWB_Rdst_address),
    .MEMWB_memRead      (MEMWB_memRead),
    .MEMWB              (MEMWB),
    .mem_stall          (mem_stall),
    .sp                 (sp)
`ifdef MEM_STAGE_TIMEOUT_EN
    ,
    .mem_timeout        (mem_timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_pass  = 0;
  int            n_total = 0;
  logic [DW-1:0] mem_model [DEPTH];
  int            sp_model;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic drive_bubble();
    exmem_valid      = 1'b0;
    exmem_memRead    = 1'b0;
    exmem_memWrite   = 1'b0;
    exmem_push       = 1'b0;
    exmem_pop        = 1'b0;
    exmem_alu_result = '0;
    exmem_store_data = '0;
    exmem_rdst       = '0;
    exmem_wb         = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with it idle.
  // wait_cyc = number of ACCESS cycles before the one carrying mem_ready.
  task automatic run_instr(input logic v, input logic push, input logic pop,
                           input logic wr, input logic rd,
                           input logic [DW-1:0] alu, input logic [DW-1:0] sdata,
                           input logic [2:0] rdst, input logic wb,
                           input int wait_cyc, output int stall_cycles);
    bit            is_mem, is_rd, is_wr;
    int            exp_addr;
    logic [DW-1:0] rdata;
    is_mem = v && (push || pop || wr || rd);
    is_wr  = v && (push || (!pop && wr));
    is_rd  = is_mem && !is_wr;
    stall_cycles = 0;

    exmem_valid = v;  exmem_push = push;  exmem_pop = pop;
    exmem_memWrite = wr;  exmem_memRead = rd;
    exmem_alu_result = alu;  exmem_store_data = sdata;
    exmem_rdst = rdst;  exmem_wb = wb;
    mem_ready = 1'($urandom_range(0, 1));   // ignored while idle
    #1;
    check("stall_idle", mem_stall, is_mem);
    check("req_idle", mem_req, 0);
    if (mem_stall) stall_cycles++;

    if (!is_mem) begin
      @(posedge clk); #1;
      check("wb_en", MEMWB, v & wb);
      check("wb_memrd", MEMWB_memRead, 0);
      check("wb_dfm", dataFromMemory, 0);
      check("wb_alu", MEMWB_ALU_result, alu);
      check("wb_rdst", MEMWB_Rdst_address, rdst);
      check("stay_idle", mem_req, 0);
      @(negedge clk);
      mem_ready = 1'b0;
    end else begin
      if (v && push) begin
        exp_addr = sp_model;
        sp_model = (sp_model + DEPTH - 1) % DEPTH;
      end else if (v && pop) begin
        sp_model = (sp_model + 1) % DEPTH;
        exp_addr = sp_model;
      end else begin
        exp_addr = int'(alu[AW-1:0]);
      end
      @(posedge clk); #1;
      check("req_enter", mem_req, 1);
      check("we", mem_we, is_wr);
      check("addr", mem_addr, exp_addr);
      if (is_wr) check("wdata", mem_wdata, sdata);
      check("sp_enter", sp, sp_model);
      check("wb_bubble_enter", MEMWB, 0);
      @(negedge clk);
      drive_bubble();   // EX/MEM contents are consumed; next is a bubble
      for (int c = 0; c <= wait_cyc; c++) begin
        mem_ready = (c == wait_cyc);
        rdata     = mem_ready ? mem_model[exp_addr] : DW'($urandom);
        mem_rdata = rdata;
        #1;
        check("stall_acc", mem_stall, 1);
        stall_cycles++;
        @(posedge clk); #1;
        if (c != wait_cyc) begin
          check("wb_bubble", MEMWB, 0);
          check("wb_bubble_rd", MEMWB_memRead, 0);
          check("req_hold", mem_req, 1);
        end else begin
          if (is_wr) mem_model[exp_addr] = sdata;
          check("req_drop", mem_req, 0);
          check("stall_drop", mem_stall, 0);
          check("wb_en_done", MEMWB, wb);
          check("wb_memrd_done", MEMWB_memRead, is_rd);
          check("wb_dfm_done", dataFromMemory, is_rd ? rdata : '0);
          check("wb_alu_done", MEMWB_ALU_result, alu);
          check("wb_rdst_done", MEMWB_Rdst_address, rdst);
        end
        @(negedge clk);
      end
      mem_ready = 1'b0;
    end
  endtask

  initial begin
    int sc;
    rst_n = 1'b0;
    drive_bubble();
    mem_ready = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < DEPTH; i++) mem_model[i] = DW'($urandom);
    sp_model = DEPTH - 1;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_stall", mem_stall, 0);
    check("rst_sp", sp, 11'h7FF);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_dfm", dataFromMemory, 0);
    check("rst_wb", MEMWB, 0);
    check("rst_wbrd", MEMWB_memRead, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ALU pass-through
    run_instr(1, 0, 0, 0, 0, 16'h1234, 16'h0, 3'd3, 1, 0, sc);
    check("alu_stall_cnt", sc, 0);

    // Load with ready on the third ACCESS cycle
    mem_model[16] = 16'hBEEF;
    run_instr(1, 0, 0, 0, 1, 16'h0010, 16'h0, 3'd5, 1, 2, sc);
    check("load_stall_cnt", sc, 4);

    // Push then pop from reset SP
    run_instr(1, 1, 0, 0, 0, 16'h0, 16'hAAAA, 3'd1, 0, 0, sc);
    check("push_sp", sp, 11'h7FE);
    run_instr(1, 0, 1, 0, 0, 16'h0, 16'h0, 3'd2, 1, 1, sc);
    check("pop_sp", sp, 11'h7FF);
    check("pop_data", dataFromMemory, 16'hAAAA);

    // Pop at top wraps to address 0, then push with memRead also set at SP = 0
    run_instr(1, 0, 1, 0, 0, 16'h0, 16'h0, 3'd4, 1, 0, sc);
    check("wrap_pop_sp", sp, 11'h000);
    run_instr(1, 1, 0, 0, 1, 16'h0155, 16'h5A5A, 3'd6, 1, 0, sc);
    check("wrap_push_sp", sp, 11'h7FF);

    // Randomized instruction stream with random memory latency
    for (int n = 0; n < 300; n++) begin
      run_instr(1'($urandom_range(0, 9) != 0),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                DW'($urandom), DW'($urandom), 3'($urandom),
                1'($urandom_range(0, 1)), $urandom_range(0, 4), sc);
    end

    // Reset during ACCESS aborts the push
    exmem_valid = 1'b1;  exmem_push = 1'b1;  exmem_store_data = 16'h7777;  exmem_wb = 1'b1;
    @(posedge clk); #1;
    check("abort_req_before", mem_req, 1);
    @(negedge clk);
    drive_bubble();
    rst_n = 1'b0;
    #1;
    check("abort_req", mem_req, 0);
    check("abort_stall", mem_stall, 0);
    check("abort_sp", sp, 11'h7FF);
    check("abort_wb", MEMWB, 0);
    sp_model = DEPTH - 1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_no_wb", MEMWB, 0);
    check("abort_idle", mem_req, 0);
    @(negedge clk);

`ifdef MEM_STAGE_TIMEOUT_EN
    // Watchdog: load with mem_ready held low
    exmem_valid = 1'b1;  exmem_memRead = 1'b1;  exmem_alu_result = 16'h0042;  exmem_wb = 1'b1;
    @(posedge clk); #1;
    check("tmo_enter", mem_req, 1);
    @(negedge clk);
    drive_bubble();
    for (int c = 0; c < 64; c++) begin
      @(posedge clk); #1;
      if (c < 63) begin
        if (mem_req !== 1'b1 || mem_timeout !== 1'b0) begin
          check("tmo_early", {mem_req, mem_timeout}, 2'b10);
          break;
        end
      end else begin
        check("tmo_pulse", mem_timeout, 1);
        check("tmo_req", mem_req, 0);
        check("tmo_stall", mem_stall, 0);
        check("tmo_wb", MEMWB, 0);
        check("tmo_dfm", dataFromMemory, 0);
      end
    end
    @(posedge clk); #1;
    check("tmo_pulse_end", mem_timeout, 0);
    @(negedge clk);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage controller between the EX/MEM pipeline register and the MEM/WB pipeline register of the five-stage processor.
- Decodes load, store, push and pop; owns the stack pointer (SP); drives a request/ready handshake to data memory.
- Stalls the pipeline until the access completes, then presents registered results to MEM/WB.

Parameters:
- DATA_W, 16, data and ALU-result width.
- ADDR_W, 11, data-memory word-address width.
- SP_RESET, 2**ADDR_W-1, SP value after reset (top of memory).
- TIMEOUT_CYC, 64, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- exmem_valid  in  1  EX/MEM holds a real instruction (0 = bubble).
- exmem_memRead  in  1  load.
- exmem_memWrite  in  1  store.
- exmem_push  in  1  push store_data.
- exmem_pop  in  1  pop into Rdst.
- exmem_alu_result  in  DATA_W  ALU result; load/store address = low ADDR_W bits.
- exmem_store_data  in  DATA_W  store/push data.
- exmem_rdst  in  3  destination register.
- exmem_wb  in  1  writeback enable.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  DATA_W  write data.
- mem_ready  in  1  access complete this cycle; mem_rdata valid.
- mem_rdata  in  DATA_W  read data.
- dataFromMemory  out  DATA_W  loaded/popped word.
- MEMWB_ALU_result  out  DATA_W  forwarded ALU result.
- MEMWB_Rdst_address  out  3  forwarded rdst.
- MEMWB_memRead  out  1  1 = write back dataFromMemory (load/pop).
- MEMWB  out  1  writeback enable to MEM/WB.
- mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- sp  out  ADDR_W  current SP, for debug and forwarding.

Behaviour:
- Reset (async, immediate): state IDLE; SP = SP_RESET; mem_req, mem_we, mem_stall and all MEMWB_* outputs = 0; mem_addr, mem_wdata and dataFromMemory = 0.
- Op selection when exmem_valid = 1: priority push > pop > memWrite > memRead. Lower-priority flags set in the same cycle are ignored.
- FSM IDLE, no memory op (including exmem_valid = 0): next posedge registers MEMWB_* from exmem_*; dataFromMemory = 0; MEMWB_memRead = 0. Latency is 1 cycle. With exmem_valid = 0 the block emits a bubble (MEMWB = 0, MEMWB_memRead = 0).
- FSM IDLE, memory op present:
  - mem_stall = 1 combinationally in the same cycle.
  - Next posedge enters ACCESS and latches the op, address, wdata, rdst, wb and alu_result.
- Address rules:
  - load/store: exmem_alu_result[ADDR_W-1:0].
  - push: SP, then SP <= SP-1 (post-decrement).
  - pop: SP+1, with SP <= SP+1 (pre-increment).
  - SP arithmetic wraps modulo 2**ADDR_W: push at 0 leaves SP = 2**ADDR_W-1; pop at 2**ADDR_W-1 reads address 0.
  - SP updates at the IDLE->ACCESS edge.
- FSM ACCESS:
  - mem_req = 1; mem_we = store|push; mem_addr/mem_wdata stable; mem_stall = 1.
  - On the posedge where mem_ready = 1: return to IDLE, drop mem_req and deassert mem_stall, and register the MEMWB_* outputs.
  - Load/pop: dataFromMemory = mem_rdata and MEMWB_memRead = 1. Store/push: MEMWB_memRead = 0 and dataFromMemory = 0.
- Bubble rule: every cycle in ACCESS without mem_ready registers MEMWB = 0 and MEMWB_memRead = 0, so MEM/WB never writes back twice.
- mem_ready in IDLE is ignored.
- The stalled EX/MEM contents are not re-decoded: after completion, IDLE resumes with the next instruction.
- Minimum memory-op latency is 2 cycles (mem_ready on the first ACCESS cycle).
- Reset asserted during ACCESS aborts the access: mem_req falls asynchronously, SP returns to SP_RESET, and no writeback occurs.

Optional Feature:
- Macro MEM_STAGE_TIMEOUT_EN.
- Defined:
  - An added output mem_timeout (1 bit, reset 0) and an internal counter cleared on ACCESS entry.
  - If TIMEOUT_CYC cycles pass in ACCESS without mem_ready: return to IDLE and drop mem_req/mem_stall.
  - Register a writeback with dataFromMemory = 0 and MEMWB = 0, and pulse mem_timeout for one cycle.
  - SP is not restored.
- Undefined: no counter and no port; ACCESS waits indefinitely.

Decomposition:
- Shared package mem_pkg: DATA_W and ADDR_W defaults, SP_RESET, op enum (OP_NONE, OP_LOAD, OP_STORE, OP_PUSH, OP_POP), FSM state enum (S_IDLE, S_ACCESS).
- Sub-module sp_unit: SP register, wrap arithmetic and address mux for push/pop. Everything else stays flat.

Test Plan:
- ALU op with rdst = 3, alu_result = 0x1234, wb = 1 -> next cycle MEMWB_ALU_result = 0x1234, MEMWB_Rdst_address = 3, MEMWB = 1, memRead = 0, mem_stall never 1.
- Load at alu_result = 0x0010, mem_ready after 3 cycles, mem_rdata = 0xBEEF -> mem_stall high 4 cycles, mem_addr = 0x010, exactly one cycle with MEMWB = 1, memRead = 1, dataFromMemory = 0xBEEF.
- Push 0xAAAA then pop, from reset -> push writes addr 0x7FF, sp = 0x7FE; pop reads 0x7FF, sp = 0x7FF, dataFromMemory = 0xAAAA.
- Push and memRead both set with SP = 0 -> push wins; mem_we = 1, addr 0x000, sp wraps to 0x7FF.
- rst_n low mid-ACCESS -> mem_req and mem_stall fall immediately, sp = 0x7FF, MEMWB = 0; with MEM_STAGE_TIMEOUT_EN and mem_ready held 0, mem_timeout pulses after 64 cycles and the stall releases.
